// File: rtl/game_pkg.sv
// Shared game types: map geometry, tile codes, controller states and winner codes.
package game_pkg;
  localparam int MAP_WIDTH  = 8;
  localparam int MAP_HEIGHT = 6;

  typedef enum logic [1:0] {EMPTY, PLAYER1, PLAYER2, FRAME} tile_t;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, OVER} game_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;
endpackage

// File: rtl/map_ctrl_if.sv
// Player request/ack channels plus the map and game status seen by the renderer.
interface map_ctrl_if #(
  parameter int MAP_W = game_pkg::MAP_WIDTH,
  parameter int MAP_H = game_pkg::MAP_HEIGHT
);
  import game_pkg::*;
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);

  logic          start;
  logic          p1_req;
  logic [XW-1:0] p1_x;
  logic [YW-1:0] p1_y;
  logic          p1_ack;
  logic          p1_crash;
  logic          p2_req;
  logic [XW-1:0] p2_x;
  logic [YW-1:0] p2_y;
  logic          p2_ack;
  logic          p2_crash;
  tile_t         map [MAP_W][MAP_H];
  logic          busy;
  logic          game_over;
  logic [1:0]    winner;

  modport slave (
    input  start, p1_req, p1_x, p1_y, p2_req, p2_x, p2_y,
    output p1_ack, p1_crash, p2_ack, p2_crash, map, busy, game_over, winner
  );
  modport master (
    output start, p1_req, p1_x, p1_y, p2_req, p2_x, p2_y,
    input  p1_ack, p1_crash, p2_ack, p2_crash, map, busy, game_over, winner
  );
endinterface

// File: rtl/map_arbiter.sv
// Two-requester round-robin: on a tie the player not served last wins.
module map_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] elig,
  output logic [1:0] grant
);
  logic rr_last;  // 0: P1 served last, 1: P2 served last

  always_comb begin
    grant = 2'b00;
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_last <= 1'b1;
    else if (|grant) rr_last <= grant[1];
  end
endmodule

// File: rtl/map_ctrl.sv
// Game map owner: clear sweep, arbitrated player tile writes, crash/winner detection.
module map_ctrl
  import game_pkg::*;
#(
  parameter int MAP_W = MAP_WIDTH,
  parameter int MAP_H = MAP_HEIGHT
) (
  input logic       clk,
  input logic       rst,
  map_ctrl_if.slave bus
);
  localparam int XW = $clog2(MAP_W);
  localparam int YW = $clog2(MAP_H);
  localparam logic [XW-1:0] X_LAST = XW'(MAP_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(MAP_H - 1);

  game_state_t   state;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  tile_t         tiles [MAP_W][MAP_H];
  logic          p1_ack, p2_ack, p1_crash, p2_crash, busy, game_over;
  logic [1:0]    winner;
  logic [1:0]    elig, grant;
  logic          collide, bad;
  logic [XW-1:0] gx;
  logic [YW-1:0] gy;

  // A player whose ack is showing this cycle is still holding the old request.
  assign elig[0] = (state == RUN) && !bus.start && bus.p1_req && !p1_ack;
  assign elig[1] = (state == RUN) && !bus.start && bus.p2_req && !p2_ack;

  map_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .elig  (elig),
    .grant (grant)
  );

  assign collide = (&elig) && (bus.p1_x == bus.p2_x) && (bus.p1_y == bus.p2_y);

  always_comb begin
    gx = bus.p1_x;
    gy = bus.p1_y;
    if (grant[1]) begin
      gx = bus.p2_x;
      gy = bus.p2_y;
    end
    bad = (int'(gx) >= MAP_W) || (int'(gy) >= MAP_H);
    if (!bad) bad = (tiles[gx][gy] != EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      p1_ack    <= 1'b0;
      p2_ack    <= 1'b0;
      p1_crash  <= 1'b0;
      p2_crash  <= 1'b0;
      busy      <= 1'b0;
      game_over <= 1'b0;
      winner    <= WIN_NONE;
      for (int i = 0; i < MAP_W; i++)
        for (int j = 0; j < MAP_H; j++)
          tiles[i][j] <= EMPTY;
    end else begin
      p1_ack <= 1'b0;
      p2_ack <= 1'b0;
      if (bus.start) begin
        state     <= CLEAR;
        cx        <= '0;
        cy        <= '0;
        busy      <= 1'b1;
        p1_crash  <= 1'b0;
        p2_crash  <= 1'b0;
        game_over <= 1'b0;
        winner    <= WIN_NONE;
      end else begin
        case (state)
          CLEAR: begin
            tiles[cx][cy] <= (cx == '0 || cx == X_LAST || cy == '0 || cy == Y_LAST)
                             ? FRAME : EMPTY;
            if (cx == X_LAST) begin
              cx <= '0;
              if (cy == Y_LAST) begin
                cy    <= '0;
                busy  <= 1'b0;
                state <= RUN;
              end else begin
                cy <= cy + 1'b1;
              end
            end else begin
              cx <= cx + 1'b1;
            end
          end
          RUN: begin
            if (collide) begin
              p1_ack    <= 1'b1;
              p2_ack    <= 1'b1;
              p1_crash  <= 1'b1;
              p2_crash  <= 1'b1;
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
              state     <= OVER;
            end else if (|grant) begin
              if (grant[0]) p1_ack <= 1'b1;
              else          p2_ack <= 1'b1;
              if (bad) begin
                if (grant[0]) begin
                  p1_crash <= 1'b1;
                  winner   <= WIN_P2;
                end else begin
                  p2_crash <= 1'b1;
                  winner   <= WIN_P1;
                end
                game_over <= 1'b1;
                state     <= OVER;
              end else begin
                tiles[gx][gy] <= grant[0] ? PLAYER1 : PLAYER2;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.p1_ack    = p1_ack;
  assign bus.p2_ack    = p2_ack;
  assign bus.p1_crash  = p1_crash;
  assign bus.p2_crash  = p2_crash;
  assign bus.busy      = busy;
  assign bus.game_over = game_over;
  assign bus.winner    = winner;
  assign bus.map       = tiles;
endmodule

// File: tb/tb_map_ctrl.sv
// Directed bench for map_ctrl on an 8x6 map; acks are checked against a queue of expected grants.
module tb_map_ctrl;
  import game_pkg::*;

  typedef struct {
    int   pl;
    logic crash;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_run  = 0;
  int   n_fail = 0;
  int   rr_m   = 2;
  exp_t exp_q[$];

  map_ctrl_if #(.MAP_W(8), .MAP_H(6)) bus ();

  map_ctrl #(.MAP_W(8), .MAP_H(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int pl);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_ack", pl, 0);
    end else begin
      e = exp_q.pop_front();
      check("ack_order", pl, e.pl);
      check("ack_crash", (pl == 1) ? bus.p1_crash : bus.p2_crash, e.crash);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.p1_ack) pop_check(1);
    if (bus.p2_ack) pop_check(2);
  endtask

  task automatic new_game();
    int cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("clear_flags", {bus.p1_crash, bus.p2_crash, bus.game_over, bus.winner}, 0);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    check("busy_cycles", cnt, 48);
  endtask

  task automatic set_req(input int pl, input int x, input int y, input logic r);
    if (pl == 1) begin
      bus.p1_x = 3'(x); bus.p1_y = 3'(y); bus.p1_req = r;
    end else begin
      bus.p2_x = 3'(x); bus.p2_y = 3'(y); bus.p2_req = r;
    end
  endtask

  task automatic single(input int pl, input int x, input int y, input logic crash);
    logic got;
    set_req(pl, x, y, 1'b1);
    exp_q.push_back('{pl, crash});
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      tick();
      if ((pl == 1 && bus.p1_ack) || (pl == 2 && bus.p2_ack)) got = 1'b1;
    end
    check("single_ack_seen", got, 1);
    set_req(pl, x, y, 1'b0);
    rr_m = pl;
  endtask

  task automatic both(input int x1, input int y1, input int x2, input int y2);
    int   first;
    logic d1, d2;
    first = (rr_m == 2) ? 1 : 2;
    set_req(1, x1, y1, 1'b1);
    set_req(2, x2, y2, 1'b1);
    exp_q.push_back('{first, 1'b0});
    exp_q.push_back('{3 - first, 1'b0});
    d1 = 1'b0;
    d2 = 1'b0;
    for (int i = 0; i < 4 && !(d1 && d2); i++) begin
      tick();
      if (bus.p1_ack) begin d1 = 1'b1; bus.p1_req = 1'b0; end
      if (bus.p2_ack) begin d2 = 1'b1; bus.p2_req = 1'b0; end
    end
    check("both_served", {d1, d2}, 2'b11);
    rr_m = 3 - first;
  endtask

  initial begin
    int   bad_tiles;
    tile_t want;
    rst = 1'b0;
    bus.start = 1'b0;
    set_req(1, 0, 0, 1'b0);
    set_req(2, 0, 0, 1'b0);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_status", {bus.game_over, bus.winner, bus.p1_crash, bus.p2_crash}, 0);
    check("rst_acks", {bus.p1_ack, bus.p2_ack}, 0);
    check("rst_tile_3_2", bus.map[3][2], EMPTY);
    check("rst_tile_0_0", bus.map[0][0], EMPTY);
    rst = 1'b0;

    // Game 1: sweep, then the border should be FRAME and the interior EMPTY
    new_game();
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 6; y++) begin
        want = (x == 0 || x == 7 || y == 0 || y == 5) ? FRAME : EMPTY;
        check("sweep_tile", bus.map[x][y], want);
      end

    set_req(1, 2, 2, 1'b1);
    exp_q.push_back('{1, 1'b0});
    tick();
    check("p1_ack_first", bus.p1_ack, 1);
    check("tile_2_2_p1", bus.map[2][2], PLAYER1);
    tick();
    check("no_reack_held", bus.p1_ack, 0);
    bus.p1_req = 1'b0;
    rr_m = 1;

    both(1, 1, 4, 3);
    single(2, 5, 1, 1'b0);
    both(1, 2, 4, 4);
    check("tile_1_1", bus.map[1][1], PLAYER1);
    check("tile_4_3", bus.map[4][3], PLAYER2);
    check("tile_5_1", bus.map[5][1], PLAYER2);
    check("tile_1_2", bus.map[1][2], PLAYER1);
    check("tile_4_4", bus.map[4][4], PLAYER2);

    single(2, 2, 2, 1'b1);
    check("occ_winner", bus.winner, WIN_P1);
    check("occ_game_over", bus.game_over, 1);
    check("occ_p1_clean", bus.p1_crash, 0);
    check("occ_tile_kept", bus.map[2][2], PLAYER1);
    set_req(1, 3, 3, 1'b1);
    repeat (3) tick();
    check("over_no_ack", bus.p1_ack, 0);
    check("over_frozen", bus.map[3][3], EMPTY);
    bus.p1_req = 1'b0;

    // Game 2: simultaneous requests for the same tile
    new_game();
    set_req(1, 3, 3, 1'b1);
    set_req(2, 3, 3, 1'b1);
    exp_q.push_back('{1, 1'b1});
    exp_q.push_back('{2, 1'b1});
    tick();
    check("draw_acks", {bus.p1_ack, bus.p2_ack}, 2'b11);
    check("draw_winner", bus.winner, WIN_DRAW);
    check("draw_game_over", bus.game_over, 1);
    check("draw_tile", bus.map[3][3], EMPTY);
    bus.p1_req = 1'b0;
    bus.p2_req = 1'b0;

    // Game 3: out-of-range row
    new_game();
    check("g3_tile_2_2", bus.map[2][2], EMPTY);
    single(1, 2, 7, 1'b1);
    check("oor_winner", bus.winner, WIN_P2);
    check("oor_p2_clean", bus.p2_crash, 0);
    check("oor_game_over", bus.game_over, 1);

    // Asynchronous reset in the middle of a sweep
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    check("mid_clear_busy", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    bad_tiles = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 6; y++)
        if (bus.map[x][y] !== EMPTY) bad_tiles++;
    check("arst_tiles_empty", bad_tiles, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_status", {bus.game_over, bus.winner, bus.p1_crash, bus.p2_crash}, 0);
    @(negedge clk);
    rst = 1'b0;
    set_req(1, 3, 3, 1'b1);
    repeat (3) tick();
    check("idle_no_ack", bus.p1_ack, 0);
    check("idle_not_busy", bus.busy, 0);
    bus.p1_req = 1'b0;
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
